// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer.
// Packs incoming audio samples into processor-width lines and writes a full
// frame of lines to an external processor. It then starts the processor,
// waits for it to finish, and streams the result lines back out one sample
// at a time.
module audio_frame_sequencer #(
  parameter  int SIZE       = 16,
  parameter  int INPUT_SIZE = 512,
  parameter  int SAMPLES    = 2048,
  localparam int LINES      = SAMPLES * SIZE / INPUT_SIZE,
  localparam int SPL        = INPUT_SIZE / SIZE,
  localparam int LW         = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       in_sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  proc_data_wr_en,
  output logic [LW-1:0]         proc_input_index,
  output logic [INPUT_SIZE-1:0] proc_data_in,
  output logic                  proc_start,
  input  logic                  proc_done,
  output logic [LW-1:0]         proc_output_index,
  input  logic [INPUT_SIZE-1:0] proc_data_out,
  output logic [SIZE-1:0]       out_sample,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int SW = (SPL > 1) ? $clog2(SPL) : 1;

  typedef enum logic [2:0] {
    FILL,
    WRITE,
    KICK,
    WAIT_BUSY,
    WAIT_DONE,
    FETCH,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           line_q, line_d;
  logic [SW-1:0]           samp_q, samp_d;
  logic [INPUT_SIZE-1:0]   buf_q, buf_d;
  logic [15:0]             frame_q, frame_d;

  // The line buffer is shared: it packs input samples while filling and
  // holds the fetched result line while draining. The two phases never overlap.
  // Next-state, counter and output decode; every output defaults to inactive.
  always_comb begin
    state_d           = state_q;
    line_d            = line_q;
    samp_d            = samp_q;
    buf_d             = buf_q;
    frame_d           = frame_q;
    in_ready          = 1'b0;
    proc_data_wr_en   = 1'b0;
    proc_input_index  = '0;
    proc_data_in      = '0;
    proc_start        = 1'b0;
    proc_output_index = '0;
    out_valid         = 1'b0;
    out_sample        = '0;
    busy              = (state_q != FILL);

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d[SIZE*int'(samp_q) +: SIZE] = in_sample;
          if (samp_q == SW'(SPL - 1)) begin
            samp_d  = '0;
            state_d = WRITE;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end

      WRITE: begin
        proc_data_wr_en  = 1'b1;
        proc_input_index = line_q;
        proc_data_in     = buf_q;
        line_d           = line_q + LW'(1);
        state_d          = (line_q == LW'(LINES - 1)) ? KICK : FILL;
      end

      KICK: begin
        proc_start = 1'b1;
        line_d     = '0;
        state_d    = WAIT_BUSY;
      end

      // The processor must drop proc_done first, so a stale idle level is
      // never taken as completion.
      WAIT_BUSY: begin
        if (!proc_done) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (proc_done) begin
          line_d  = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        proc_output_index = line_q;
        buf_d             = proc_data_out;
        samp_d            = '0;
        state_d           = SEND;
      end

      SEND: begin
        proc_output_index = line_q;
        out_valid         = 1'b1;
        out_sample        = buf_q[SIZE*int'(samp_q) +: SIZE];
        if (out_ready) begin
          if (samp_q == SW'(SPL - 1)) begin
            samp_d = '0;
            if (line_q == LW'(LINES - 1)) begin
              line_d  = '0;
              frame_d = frame_q + 16'd1;
              state_d = FILL;
            end else begin
              line_d  = line_q + LW'(1);
              state_d = FETCH;
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign frame_count = frame_q;

  // State and datapath registers with synchronous reset back to an empty FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      line_q  <= '0;
      samp_q  <= '0;
      buf_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      samp_q  <= samp_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed testbench for audio_frame_sequencer, using the default parameters
// (16-bit samples, 512-bit lines, 2048-sample frames).
module tb_audio_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  in_sample = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         proc_data_wr_en;
  logic [5:0]   proc_input_index;
  logic [511:0] proc_data_in;
  logic         proc_start;
  logic         proc_done = 1'b1;
  logic [5:0]   proc_output_index;
  logic [511:0] proc_data_out;
  logic [15:0]  out_sample;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [15:0]  frame_count;

  int n_compared = 0;
  int n_mismatched = 0;

  audio_frame_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .in_sample         (in_sample),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .proc_data_wr_en   (proc_data_wr_en),
    .proc_input_index  (proc_input_index),
    .proc_data_in      (proc_data_in),
    .proc_start        (proc_start),
    .proc_done         (proc_done),
    .proc_output_index (proc_output_index),
    .proc_data_out     (proc_data_out),
    .out_sample        (out_sample),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .frame_count       (frame_count)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp events.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor model: the line memory loops written lines straight back out.
  // After a start it either drops proc_done for ten cycles or, in hold-high
  // mode, never drops it at all.
  logic [511:0] mem [64];
  bit           hold_high = 1'b0;
  int           busy_cnt = 0;
  assign proc_data_out = mem[proc_output_index];

  always @(posedge clk) begin
    if (proc_start && !hold_high) begin
      proc_done <= 1'b0;
      busy_cnt  <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) proc_done <= 1'b1;
    end
  end

  // Event monitor, sampling in mid-cycle: line writes, start pulses, strobe
  // overlap, the first rises of proc_done and out_valid, and out_valid cycles.
  int wr_cnt = 0;
  int last_wr_cyc = -1;
  int start_cnt = 0;
  int start_cyc = -1;
  int overlap_cnt = 0;
  int done_rise_first = -1;
  int ov_rise_first = -1;
  int ov_cycles = 0;
  bit prev_done = 1'b1;

  always @(negedge clk) begin
    if (proc_data_wr_en) begin
      mem[proc_input_index] = proc_data_in;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (proc_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (proc_data_wr_en && proc_start) overlap_cnt++;
    if (proc_done && !prev_done && done_rise_first < 0) done_rise_first = cyc;
    prev_done = proc_done;
    if (out_valid) begin
      ov_cycles++;
      if (ov_rise_first < 0) ov_rise_first = cyc;
    end
  end

  // Output collector: every handshaken sample must equal its position in the
  // stream, which catches reordering, drops and duplicates.
  int got_count = 0;
  int order_err = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (out_sample != 16'(got_count)) order_err++;
      got_count++;
    end
  end

  // Compares one observed value with its expected value and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers count samples with values base, base+1, ... while holding in_valid
  // high, and returns the cycle in which the last one was accepted.
  task automatic applyStimulus(input int base, input int count, output int last_cyc, output bit ok);
    int sent = 0;
    int guard = 0;
    bit acc;
    last_cyc = -1;
    in_valid = 1'b1;
    in_sample = 16'(base);
    while (sent < count && guard < count * 3 + 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && sent == count - 1) last_cyc = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_sample = 16'(base + sent);
      end
      guard++;
    end
    in_valid = 1'b0;
    ok = (sent == count);
  endtask

  int  last_acc;
  bit  ok;
  int  base_start;
  int  base_wr;
  int  base_ov;
  int  guard;
  bit  toggle;
  bit  held;
  int  hold_bad;
  logic [15:0] held_val;

  initial begin
    // Reset and check the idle state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_wr_en", 32'(proc_data_wr_en), 32'd0);
    checkOutput("rst_start", 32'(proc_start), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_out_index", 32'(proc_output_index), 32'd0);
    checkOutput("rst_data_in_zero", 32'(proc_data_in != '0), 32'd0);
    @(posedge clk);
    #1;

    // Frame 1: samples 0..2047 with in_valid held high throughout.
    base_start = start_cnt;
    base_wr = wr_cnt;
    applyStimulus(0, 2048, last_acc, ok);
    checkOutput("feed1_done", 32'(ok), 32'd1);
    guard = 0;
    while (start_cnt == base_start && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput("wr_pulses", 32'(wr_cnt - base_wr), 32'd64);
    checkOutput("start_pulses", 32'(start_cnt - base_start), 32'd1);
    checkOutput("wr_latency", 32'(last_wr_cyc - last_acc), 32'd1);
    checkOutput("start_latency", 32'(start_cyc - last_acc), 32'd2);
    checkOutput("strobe_overlap", 32'(overlap_cnt), 32'd0);
    checkOutput("line0_low", 32'(mem[0][15:0]), 32'h0000);
    checkOutput("line0_top", 32'(mem[0][511:496]), 32'h001F);
    checkOutput("line63_low", 32'(mem[63][15:0]), 32'h07E0);
    checkOutput("line63_top", 32'(mem[63][511:496]), 32'h07FF);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    checkOutput("wait_in_ready", 32'(in_ready), 32'd0);
    checkOutput("wait_out_valid", 32'(out_valid), 32'd0);

    // Drain with out_ready toggling, plus a 20-cycle stall in the middle of line 1.
    toggle = 1'b0;
    held = 1'b0;
    hold_bad = 0;
    held_val = '0;
    guard = 0;
    while (got_count < 2048 && guard < 12000) begin
      @(posedge clk);
      #1;
      if (!held && got_count == 40) begin
        held = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        held_val = out_sample;
        for (int i = 0; i < 20; i++) begin
          if (i > 0) @(negedge clk);
          if (!out_valid || out_sample != held_val) hold_bad++;
        end
      end else begin
        toggle = !toggle;
        out_ready = toggle;
      end
      guard++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_rise", 32'(done_rise_first - start_cyc), 32'd11);
    checkOutput("fetch_on_done", 32'(ov_rise_first - start_cyc), 32'd13);
    checkOutput("hold_sample", 32'(held_val), 32'd40);
    checkOutput("hold_stable", 32'(hold_bad), 32'd0);
    checkOutput("out_count", 32'(got_count), 32'd2048);
    checkOutput("out_order", 32'(order_err), 32'd0);
    checkOutput("frame_count_1", 32'(frame_count), 32'd1);
    checkOutput("post_drain_busy", 32'(busy), 32'd0);
    checkOutput("post_drain_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset after 100 accepted samples, then a fresh frame.
    applyStimulus(16'h5000, 100, last_acc, ok);
    checkOutput("feed_partial_done", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1;

    // Second frame with proc_done stuck high: the sequencer must stay waiting.
    hold_high = 1'b1;
    base_start = start_cnt;
    base_wr = wr_cnt;
    base_ov = ov_cycles;
    applyStimulus(16'h4000, 2048, last_acc, ok);
    checkOutput("feed2_done", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    checkOutput("f2_wr_pulses", 32'(wr_cnt - base_wr), 32'd64);
    checkOutput("f2_line0_low", 32'(mem[0][15:0]), 32'h4000);
    checkOutput("f2_line0_w1", 32'(mem[0][31:16]), 32'h4001);
    checkOutput("f2_line63_top", 32'(mem[63][511:496]), 32'h47FF);
    checkOutput("f2_start_pulses", 32'(start_cnt - base_start), 32'd1);
    checkOutput("f2_no_fetch", 32'(ov_cycles - base_ov), 32'd0);
    checkOutput("f2_busy", 32'(busy), 32'd1);
    checkOutput("f2_in_ready", 32'(in_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
